// File: rtl/spi_avalon_bridge_if.sv
// Avalon-MM slave bus bundle for spi_avalon_bridge.
//   avs_address   [1:0]  word address
//   avs_read             read strobe
//   avs_write            write strobe
//   avs_writedata [31:0] write data
//   avs_readdata  [31:0] registered read data (latency 1)
// master: CPU / fabric side; slave: the bridge.
interface spi_avalon_bridge_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/spi_avalon_bridge.sv
// Avalon-MM front end for the SPI master core. CPU words are queued in a TX
// FIFO and sent one SPI transfer at a time; returned words land in an RX FIFO.
// Register map: 0 TXDATA (W push / R 0), 1 RXDATA (R pop), 2 STATUS
// (R, W1C [7:5]), 3 CONTROL ([0] enable, [1] irq_en).
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   avs              Avalon-MM slave bundle (spi_avalon_bridge_if.slave)
//   spi_go           one-cycle launch pulse to the SPI core
//   spi_wdata        word being transmitted, stable for the whole transfer
//   spi_rdata        word received by the core
//   spi_done         core completion level; completion is its rising edge
//   irq              interrupt, present only when SPI_BRIDGE_IRQ_EN is defined
// Optional feature macro: SPI_BRIDGE_IRQ_EN (irq port and CONTROL[1]).
module spi_avalon_bridge #(
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  spi_avalon_bridge_if.slave     avs,
  output logic                   spi_go,
  output logic [31:0]            spi_wdata,
  input  logic [31:0]            spi_rdata,
  input  logic                   spi_done
`ifdef SPI_BRIDGE_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned IW    = (FIFO_AW > 0) ? FIFO_AW : 1;
  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_DONE, STORE} state_t;
  state_t state_q, state_d;

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd, tx_lvl, rx_lvl;
  logic [IW-1:0] tx_wa, tx_ra, rx_wa, rx_ra;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          wr_tx, wr_st, wr_ctl, rd_rx;
  logic          tx_ovf, rx_unf, tmo_flag, tx_ovf_set, rx_unf_set, tmo_set;
  logic          enable, irq_en, done_d, done_rise;
  logic [31:0]   tmo_cnt, status;

  // A depth-1 FIFO has no address bits; its single slot is always index 0.
  always_comb begin
    tx_wa = (FIFO_AW == 0) ? '0 : IW'(tx_wr);
    tx_ra = (FIFO_AW == 0) ? '0 : IW'(tx_rd);
    rx_wa = (FIFO_AW == 0) ? '0 : IW'(rx_wr);
    rx_ra = (FIFO_AW == 0) ? '0 : IW'(rx_rd);
  end

  assign tx_lvl   = tx_wr - tx_rd;
  assign rx_lvl   = rx_wr - rx_rd;
  assign tx_full  = (tx_lvl == PW'(DEPTH));
  assign rx_full  = (rx_lvl == PW'(DEPTH));
  assign tx_empty = (tx_lvl == '0);
  assign rx_empty = (rx_lvl == '0);

  assign wr_tx  = avs.avs_write && (avs.avs_address == 2'd0);
  assign wr_st  = avs.avs_write && (avs.avs_address == 2'd2);
  assign wr_ctl = avs.avs_write && (avs.avs_address == 2'd3);
  assign rd_rx  = avs.avs_read  && (avs.avs_address == 2'd1);

  assign tx_pop     = (state_q == LAUNCH);
  assign tx_push    = wr_tx && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_tx && tx_full && !tx_pop;
  assign rx_push    = (state_q == STORE);
  assign rx_pop     = rd_rx && !rx_empty;
  assign rx_unf_set = rd_rx && rx_empty;
  assign done_rise  = spi_done && !done_d;

  // spi_go is a decode of the LAUNCH state; spi_wdata is loaded on the edge
  // entering LAUNCH so the word is already valid during the spi_go cycle.
  assign spi_go = (state_q == LAUNCH);

  always_comb begin
    state_d = state_q;
    tmo_set = 1'b0;
    case (state_q)
      IDLE:      if (enable && !tx_empty && !rx_full) state_d = LAUNCH;
      LAUNCH:    state_d = spi_done ? WAIT_LOW : WAIT_DONE;
      WAIT_LOW:  if (!spi_done) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_rise) begin
          state_d = STORE;
        end else if (TMO_EN && (tmo_cnt >= TMO_LAST)) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      STORE:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign status = {8'd0, 8'(rx_lvl), 8'(tx_lvl), tmo_flag, rx_unf, tx_ovf,
                   (state_q != IDLE), rx_empty, rx_full, tx_empty, tx_full};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wa] <= avs.avs_writedata;
    if (rx_push) rx_mem[rx_wa] <= spi_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      done_d           <= 1'b0;
      tmo_cnt          <= '0;
      spi_wdata        <= '0;
      tx_wr            <= '0;
      tx_rd            <= '0;
      rx_wr            <= '0;
      rx_rd            <= '0;
      tx_ovf           <= 1'b0;
      rx_unf           <= 1'b0;
      tmo_flag         <= 1'b0;
      enable           <= 1'b0;
      avs.avs_readdata <= '0;
    end else begin
      state_q <= state_d;
      done_d  <= spi_done;
      if (state_q == LAUNCH)
        tmo_cnt <= '0;
      else if (state_q == WAIT_LOW || state_q == WAIT_DONE)
        tmo_cnt <= tmo_cnt + 32'd1;
      if (state_q == IDLE && state_d == LAUNCH) spi_wdata <= tx_mem[tx_ra];
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      // Set events take priority over a same-cycle write-1-to-clear.
      tx_ovf   <= tx_ovf_set | (tx_ovf   & ~(wr_st & avs.avs_writedata[5]));
      rx_unf   <= rx_unf_set | (rx_unf   & ~(wr_st & avs.avs_writedata[6]));
      tmo_flag <= tmo_set    | (tmo_flag & ~(wr_st & avs.avs_writedata[7]));
      if (wr_ctl) enable <= avs.avs_writedata[0];
      if (avs.avs_read) begin
        case (avs.avs_address)
          2'd0:    avs.avs_readdata <= '0;
          2'd1:    avs.avs_readdata <= rx_empty ? '0 : rx_mem[rx_ra];
          2'd2:    avs.avs_readdata <= status;
          default: avs.avs_readdata <= {30'd0, irq_en, enable};
        endcase
      end
    end
  end

`ifdef SPI_BRIDGE_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctl) irq_en <= avs.avs_writedata[1];
      irq <= irq_en & (~rx_empty | tx_ovf | rx_unf | tmo_flag);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_spi_avalon_bridge.sv
// Self-checking bench for spi_avalon_bridge: random words through a queue
// model of the FIFOs and flags, with a behavioural SPI core that answers each
// launched word with (word ^ 32'hFFFF_5115) after a programmable delay.
module tb_spi_avalon_bridge;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 64;
  localparam logic [31:0] RESP_XOR = 32'hFFFF_5115;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] spi_rdata = '0;
  logic        spi_done = 1'b0;
  logic        spi_go;
  logic [31:0] spi_wdata;
`ifdef SPI_BRIDGE_IRQ_EN
  logic        irq;
`endif

  spi_avalon_bridge_if bus();

  spi_avalon_bridge #(.FIFO_AW(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (bus),
    .spi_go    (spi_go),
    .spi_wdata (spi_wdata),
    .spi_rdata (spi_rdata),
    .spi_done  (spi_done)
`ifdef SPI_BRIDGE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  logic [31:0] m_go[$];
  bit m_en = 0, m_ovf = 0, m_unf = 0, m_tmo = 0;

  // Observed launches and behavioural core
  logic [31:0] go_seen[$];
  int unsigned served = 0;
  int unsigned dly_lo = 5, dly_hi = 5, hold_lo = 1, hold_hi = 3;
  bit core_mute = 0;

  always @(negedge clk) if (spi_go === 1'b1) go_seen.push_back(spi_wdata);

  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (go_seen.size() > served) begin
        w = go_seen[served];
        served++;
        if (!core_mute) begin
          repeat ($urandom_range(dly_hi, dly_lo)) @(negedge clk);
          spi_rdata = w ^ RESP_XOR;
          spi_done  = 1'b1;
          repeat ($urandom_range(hold_hi, hold_lo)) @(negedge clk);
          spi_done  = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {8'd0, 8'(m_rx.size()), 8'(m_tx.size()), m_tmo, m_unf, m_ovf, 1'b0,
            m_rx.size() == 0, m_rx.size() == DEPTH, m_tx.size() == 0, m_tx.size() == DEPTH};
  endfunction

  task automatic m_write_tx(input logic [31:0] w);
    if (m_tx.size() < DEPTH) m_tx.push_back(w);
    else m_ovf = 1;
  endtask

  task automatic m_settle();
    logic [31:0] w;
    while (m_en && m_tx.size() > 0 && m_rx.size() < DEPTH) begin
      w = m_tx.pop_front();
      m_go.push_back(w);
      m_rx.push_back(w ^ RESP_XOR);
    end
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  int unsigned go_checked = 0;

  // Wait (bounded) until the DUT has launched every word the model expects
  // and is idle, then compare the launched words in order.
  task automatic settle(input string tag);
    logic [31:0] st;
    bit ok = 0;
    for (int n = 0; n < 1500; n++) begin
      av_read(2'd2, st);
      if (go_seen.size() == m_go.size() && st[4] == 1'b0) begin ok = 1; break; end
    end
    repeat (4) @(negedge clk);
    check({"settle_", tag}, 32'(ok), 32'd1);
    check({"go_count_", tag}, go_seen.size(), m_go.size());
    while (go_checked < go_seen.size() && go_checked < m_go.size()) begin
      check({"go_word_", tag}, go_seen[go_checked], m_go[go_checked]);
      go_checked++;
    end
  endtask

  task automatic wait_go(input string tag);
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (go_seen.size() >= m_go.size()) begin ok = 1; break; end
      @(negedge clk);
    end
    check({"wait_go_", tag}, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    while (m_rx.size() > 0) begin
      av_read(2'd1, d);
      check({"rxdata_", tag}, d, m_rx.pop_front());
    end
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    av_read(2'd2, d);
    check({"status_", tag}, d, m_status());
  endtask

  initial begin
    logic [31:0] d, w;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_go", 32'(spi_go), 32'd0);
    check("rst_wdata", spi_wdata, 32'd0);
    check("rst_readdata", bus.avs_readdata, 32'd0);
    reset_n = 1'b1;

    av_read(2'd2, d);
    check("reset_status", d, 32'h0000_000A);

    // Disabled: queue three words, no launch allowed
    for (int i = 0; i < 3; i++) begin
      w = $urandom; av_write(2'd0, w); m_write_tx(w);
    end
    repeat (20) @(negedge clk);
    check("no_go_disabled", go_seen.size(), 32'd0);
    av_read(2'd2, d);
    check("tx_level_3", 32'(d[15:8]), 32'd3);
    check("status_3q", d, m_status());

    // Enable with a slow core (40 cycles)
    dly_lo = 40; dly_hi = 40;
    av_write(2'd0, 32'hA5A5_1234); m_write_tx(32'hA5A5_1234);
    av_write(2'd3, 32'd1); m_en = 1;
    m_settle();
    settle("first");
    check("wdata_hold", spi_wdata, 32'hA5A5_1234);
    for (int i = 0; i < 3; i++) begin
      av_read(2'd1, d); check("rx_first", d, m_rx.pop_front());
    end
    av_read(2'd1, d);
    check("rx_literal", d, 32'h5A5A_4321);
    void'(m_rx.pop_front());
    chk_status("after_first");

    // Overflow, W1C, fill RX, stall on RX full
    dly_lo = 2; dly_hi = 12; hold_lo = 1; hold_hi = 6;
    av_write(2'd3, 32'd0); m_en = 0;
    for (int i = 0; i < 9; i++) begin
      w = $urandom; av_write(2'd0, w); m_write_tx(w);
    end
    chk_status("ovf");
    av_write(2'd2, 32'h20); m_ovf = 0;
    chk_status("ovf_clr");
    av_write(2'd3, 32'd1); m_en = 1;
    m_settle();
    settle("fill_rx");
    chk_status("rx_full");
    w = $urandom; av_write(2'd0, w); m_write_tx(w);
    repeat (30) @(negedge clk);
    check("stall_rx_full", go_seen.size(), m_go.size());
    av_read(2'd1, d); check("rx_pop_unstall", d, m_rx.pop_front());
    m_settle();
    settle("unstall");
    drain("fill");
    chk_status("drained");

    // Underflow read
    av_read(2'd1, d);
    check("rx_empty_read", d, 32'd0);
    m_unf = 1;
    chk_status("unf");
    av_write(2'd2, 32'h40); m_unf = 0;

    // CPU push into a full TX FIFO in the same cycle as the LAUNCH pop
    av_write(2'd3, 32'd0); m_en = 0;
    for (int i = 0; i < 8; i++) begin
      w = $urandom; av_write(2'd0, w); m_write_tx(w);
    end
    chk_status("tx_full");
    w = $urandom;
    av_write(2'd3, 32'd1); m_en = 1;
    av_write(2'd0, w);
    m_tx.push_back(w);
    m_settle();
    settle("simul");
    chk_status("simul");
    drain("simul_a");
    m_settle();
    settle("simul_tail");
    drain("simul_b");
    chk_status("simul_end");

    // Timeout: core never answers
    core_mute = 1;
    w = $urandom; av_write(2'd0, w);
    m_go.push_back(w); m_tmo = 1;
    wait_go("tmo");
    repeat (TMO / 2) @(negedge clk);
    av_read(2'd2, d);
    check("busy_waiting", 32'(d[4]), 32'd1);
    settle("tmo");
    chk_status("tmo");
    core_mute = 0;
    w = $urandom; av_write(2'd0, w); m_write_tx(w);
    m_settle();
    settle("after_tmo");
    drain("after_tmo");
    av_write(2'd2, 32'h80); m_tmo = 0;
    chk_status("tmo_clr");

    // Random bursts with random core latency
    for (int r = 0; r < 6; r++) begin
      dly_hi = $urandom_range(20, 1);
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) begin
        w = $urandom; av_write(2'd0, w); m_write_tx(w);
      end
      m_settle();
      settle("rand");
      drain("rand");
      chk_status("rand");
    end

`ifdef SPI_BRIDGE_IRQ_EN
    check("irq_idle", 32'(irq), 32'd0);
    av_write(2'd3, 32'd3);
    w = $urandom; av_write(2'd0, w); m_write_tx(w);
    m_settle();
    settle("irq");
    check("irq_set", 32'(irq), 32'd1);
    av_read(2'd1, d); check("rx_irq", d, m_rx.pop_front());
    check("irq_hold_pop_cycle", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_drop", 32'(irq), 32'd0);
    av_write(2'd3, 32'd1);
`else
    av_write(2'd3, 32'd3);
    av_read(2'd3, d);
    check("ctrl_irq_en_ro", d, 32'd1);
    av_write(2'd3, 32'd1);
`endif

    // Asynchronous reset in the middle of a transfer
    dly_lo = 40; dly_hi = 40;
    w = $urandom | 32'h1; av_write(2'd0, w);
    m_go.push_back(w);
    wait_go("rst");
    av_read(2'd3, d);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_go", 32'(spi_go), 32'd0);
    check("rst_mid_wdata", spi_wdata, 32'd0);
    check("rst_mid_readdata", bus.avs_readdata, 32'd0);
`ifdef SPI_BRIDGE_IRQ_EN
    check("rst_mid_irq", 32'(irq), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    m_tx.delete(); m_rx.delete();
    m_en = 0; m_ovf = 0; m_unf = 0; m_tmo = 0;
    go_checked = go_seen.size();
    av_read(2'd2, d);
    check("post_rst_status", d, 32'h0000_000A);
    av_read(2'd3, d);
    check("post_rst_ctrl", d, 32'd0);
    repeat (50) @(negedge clk);
    check("post_rst_no_go", go_seen.size(), m_go.size());
    chk_status("post_rst_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
